// File: rtl/lv_efuse_load_ctrl.sv
// ---------------------------------------------------------------------------
// lv_efuse_load_ctrl
//
// Responder for the LV control FSM efuse-load handshake. On a load request it
// reads EFUSE_WORD_NUM words from the efuse macro (csb/strobe read cycle),
// copies every word into the register file, XOR-checks the trailing checksum
// word and reports valid / crc-error status plus a one-cycle done pulse.
//
// Ports
//   i_clk               clock
//   i_rst               synchronous reset, active-high
//   i_efuse_load_req    level load request from the control FSM
//   o_efuse_load_done   one-cycle pulse, load finished
//   o_efuse_vld         efuse contents valid (checksum ok, not blank)
//   o_efuse_crc_err     checksum mismatch on a non-blank efuse
//   o_efuse_busy        high whenever the FSM is not idle
//   o_efuse_csb         efuse macro chip select, active-low
//   o_efuse_strobe      efuse read strobe
//   o_efuse_addr        efuse word address
//   i_efuse_rdata       efuse read data, valid after strobe falls
//   o_reg_efuse_wr_en   register-file write pulse
//   o_reg_efuse_wr_addr register-file write address
//   o_reg_efuse_wr_data register-file write data
// ---------------------------------------------------------------------------
module lv_efuse_load_ctrl #(
    parameter int unsigned EFUSE_WORD_NUM = 8,
    parameter int unsigned EFUSE_DATA_W   = 8,
    parameter int unsigned EFUSE_ADDR_W   = 3,
    parameter int unsigned RD_SETUP_CYC   = 2,
    parameter int unsigned RD_PULSE_CYC   = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_efuse_load_req,
    output logic                    o_efuse_load_done,
    output logic                    o_efuse_vld,
    output logic                    o_efuse_crc_err,
    output logic                    o_efuse_busy,
    output logic                    o_efuse_csb,
    output logic                    o_efuse_strobe,
    output logic [EFUSE_ADDR_W-1:0] o_efuse_addr,
    input  logic [EFUSE_DATA_W-1:0] i_efuse_rdata,
    output logic                    o_reg_efuse_wr_en,
    output logic [EFUSE_ADDR_W-1:0] o_reg_efuse_wr_addr,
    output logic [EFUSE_DATA_W-1:0] o_reg_efuse_wr_data
);

    // Phase timer only has to reach the longer of the two read phases.
    localparam int unsigned TIM_MAX = (RD_SETUP_CYC > RD_PULSE_CYC) ? RD_SETUP_CYC : RD_PULSE_CYC;
    localparam int unsigned TIM_W   = (TIM_MAX > 1) ? $clog2(TIM_MAX) : 1;

    localparam logic [EFUSE_ADDR_W-1:0] LAST_WORD = EFUSE_ADDR_W'(EFUSE_WORD_NUM - 1);
    localparam logic [TIM_W-1:0]        SETUP_END = TIM_W'(RD_SETUP_CYC - 1);
    localparam logic [TIM_W-1:0]        PULSE_END = TIM_W'(RD_PULSE_CYC - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STRB    = 3'd2;
    localparam logic [2:0] ST_CAPT    = 3'd3;
    localparam logic [2:0] ST_CHK     = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;
    localparam logic [2:0] ST_REQ_LOW = 3'd6;

    logic [2:0]              state_q,   state_d;
    logic [EFUSE_ADDR_W-1:0] cnt_q,     cnt_d;
    logic [TIM_W-1:0]        tmr_q,     tmr_d;
    logic [EFUSE_DATA_W-1:0] acc_q,     acc_d;
    logic                    blank_q,   blank_d;
    logic                    vld_q,     vld_d;
    logic                    crc_q,     crc_d;
    logic                    done_q,    done_d;
    logic                    busy_q,    busy_d;
    logic                    csb_q,     csb_d;
    logic                    strobe_q,  strobe_d;
    logic                    wr_en_q,   wr_en_d;
    logic [EFUSE_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [EFUSE_DATA_W-1:0] wr_data_q, wr_data_d;

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tmr_q     <= '0;
            acc_q     <= '0;
            blank_q   <= 1'b0;
            vld_q     <= 1'b0;
            crc_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            csb_q     <= 1'b1;
            strobe_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            acc_q     <= acc_d;
            blank_q   <= blank_d;
            vld_q     <= vld_d;
            crc_q     <= crc_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            csb_q     <= csb_d;
            strobe_q  <= strobe_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        acc_d     = acc_q;
        blank_d   = blank_q;
        vld_d     = vld_q;
        crc_d     = crc_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            ST_IDLE: begin
                if (i_efuse_load_req) begin
                    state_d = ST_SETUP;
                    vld_d   = 1'b0;
                    crc_d   = 1'b0;
                    cnt_d   = '0;
                    tmr_d   = '0;
                    acc_d   = '0;
                    blank_d = 1'b1;
                end
            end
            ST_SETUP: begin
                if (tmr_q == SETUP_END) begin
                    state_d = ST_STRB;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TIM_W'(1);
                end
            end
            ST_STRB: begin
                if (tmr_q == PULSE_END) begin
                    state_d = ST_CAPT;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TIM_W'(1);
                end
            end
            ST_CAPT: begin
                // The sample goes straight into the write registers, so the
                // register-file write lands in the following cycle.
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = i_efuse_rdata;
                blank_d   = blank_q & (i_efuse_rdata == '0);
                if (cnt_q == LAST_WORD) begin
                    state_d = ST_CHK;
                end else begin
                    acc_d   = acc_q ^ i_efuse_rdata;
                    cnt_d   = cnt_q + EFUSE_ADDR_W'(1);
                    state_d = ST_SETUP;
                end
            end
            ST_CHK: begin
                // wr_data_q still holds the checksum word captured last.
                vld_d   = ~blank_q & (acc_q == wr_data_q);
                crc_d   = ~blank_q & (acc_q != wr_data_q);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_REQ_LOW;
            end
            ST_REQ_LOW: begin
                // Wait for the requester to drop req so a late drop cannot re-trigger.
                if (!i_efuse_load_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Interface outputs are decoded from the next state so they are registered.
    always_comb begin
        busy_d   = (state_d != ST_IDLE);
        strobe_d = (state_d == ST_STRB);
        csb_d    = ~((state_d == ST_SETUP) | (state_d == ST_STRB) | (state_d == ST_CAPT));
        done_d   = (state_q == ST_DONE);
    end

    assign o_efuse_load_done   = done_q;
    assign o_efuse_vld         = vld_q;
    assign o_efuse_crc_err     = crc_q;
    assign o_efuse_busy        = busy_q;
    assign o_efuse_csb         = csb_q;
    assign o_efuse_strobe      = strobe_q;
    assign o_efuse_addr        = cnt_q;
    assign o_reg_efuse_wr_en   = wr_en_q;
    assign o_reg_efuse_wr_addr = wr_addr_q;
    assign o_reg_efuse_wr_data = wr_data_q;

endmodule

// File: tb/tb_lv_efuse_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lv_efuse_load_ctrl
//
// Self-checking bench: a behavioural efuse array answers reads, a reference
// model derives write list, checksum status and latency from the array
// contents, and a monitor checks the csb/strobe read timing.
// ---------------------------------------------------------------------------
module tb_lv_efuse_load_ctrl;

    localparam int N   = 8;
    localparam int S   = 2;
    localparam int P   = 4;
    localparam int LAT = N * (S + P + 1) + 2;

    logic       clk;
    logic       rst;
    logic       req;
    logic       o_efuse_load_done;
    logic       o_efuse_vld;
    logic       o_efuse_crc_err;
    logic       o_efuse_busy;
    logic       o_efuse_csb;
    logic       o_efuse_strobe;
    logic [2:0] o_efuse_addr;
    logic [7:0] i_efuse_rdata;
    logic       o_reg_efuse_wr_en;
    logic [2:0] o_reg_efuse_wr_addr;
    logic [7:0] o_reg_efuse_wr_data;

    logic [7:0]  mem [N];
    logic [7:0]  junk;
    logic [15:0] wq [$];

    int checks   = 0;
    int failures = 0;

    lv_efuse_load_ctrl #(
        .EFUSE_WORD_NUM (N),
        .EFUSE_DATA_W   (8),
        .EFUSE_ADDR_W   (3),
        .RD_SETUP_CYC   (S),
        .RD_PULSE_CYC   (P)
    ) u_dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_efuse_load_req    (req),
        .o_efuse_load_done   (o_efuse_load_done),
        .o_efuse_vld         (o_efuse_vld),
        .o_efuse_crc_err     (o_efuse_crc_err),
        .o_efuse_busy        (o_efuse_busy),
        .o_efuse_csb         (o_efuse_csb),
        .o_efuse_strobe      (o_efuse_strobe),
        .o_efuse_addr        (o_efuse_addr),
        .i_efuse_rdata       (i_efuse_rdata),
        .o_reg_efuse_wr_en   (o_reg_efuse_wr_en),
        .o_reg_efuse_wr_addr (o_reg_efuse_wr_addr),
        .o_reg_efuse_wr_data (o_reg_efuse_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Efuse macro: data only meaningful while selected and strobe low.
    always_comb begin
        i_efuse_rdata = (!o_efuse_csb && !o_efuse_strobe) ? mem[o_efuse_addr] : junk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Read-timing monitor and register-write capture.
    int         pre_cnt;
    int         strb_cnt;
    int         nstrb;
    bit         first;
    bit         prev_strb;
    logic [2:0] strb_addr;

    always @(negedge clk) begin
        junk = 8'($urandom);
        if (rst) begin
            pre_cnt   = 0;
            strb_cnt  = 0;
            nstrb     = 0;
            first     = 1'b1;
            prev_strb = 1'b0;
        end else begin
            if (o_reg_efuse_wr_en) wq.push_back({5'd0, o_reg_efuse_wr_addr, o_reg_efuse_wr_data});
            if (o_efuse_strobe) begin
                if (!prev_strb) begin
                    chk("setup_cycles", 32'(pre_cnt), first ? 32'(S) : 32'(S + 1));
                    chk("strobe_addr", 32'(o_efuse_addr), 32'(nstrb));
                    chk("strobe_csb", 32'(o_efuse_csb), 32'(0));
                    strb_addr = o_efuse_addr;
                    first     = 1'b0;
                    nstrb++;
                end else if (o_efuse_addr != strb_addr) begin
                    chk("addr_stable", 32'(o_efuse_addr), 32'(strb_addr));
                end
                strb_cnt++;
                pre_cnt = 0;
            end else begin
                if (prev_strb) chk("pulse_cycles", 32'(strb_cnt), 32'(P));
                strb_cnt = 0;
                if (!o_efuse_csb) begin
                    pre_cnt++;
                end else begin
                    pre_cnt = 0;
                    nstrb   = 0;
                    first   = 1'b1;
                end
            end
            prev_strb = o_efuse_strobe;
        end
    end

    // mode 0: random data + correct checksum, 1: random checksum, 2: blank
    task automatic fill_mem(input int mode);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < N - 1; i++) begin
            mem[i] = (mode == 2) ? 8'h00 : 8'($urandom);
            x      = x ^ mem[i];
        end
        mem[N-1] = (mode == 0) ? x : (mode == 1) ? 8'($urandom) : 8'h00;
    endtask

    // One full load started on a negedge; drop_after>0 drops req after that many cycles,
    // hold_cycles>0 keeps req high that long after done.
    task automatic run_load(input string nm, input int drop_after, input int hold_cycles);
        int         n;
        int         act;
        bit         got;
        bit         blank;
        logic [7:0] x;
        logic       ev;
        logic       ec;
        x     = 8'h00;
        blank = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (i < N - 1) x = x ^ mem[i];
            if (mem[i] != 8'h00) blank = 1'b0;
        end
        ev = !blank && (x == mem[N-1]);
        ec = !blank && (x != mem[N-1]);
        wq.delete();
        req = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1)
                chk({nm, "_start"}, 32'({o_efuse_busy, o_efuse_vld, o_efuse_crc_err, o_efuse_csb}), 32'(4'b1000));
            if (drop_after > 0 && n == drop_after) req = 1'b0;
            if (o_efuse_load_done) got = 1'b1;
        end
        chk({nm, "_latency"}, 32'(n - 1), 32'(LAT));
        chk({nm, "_vld"}, 32'(o_efuse_vld), 32'(ev));
        chk({nm, "_crc_err"}, 32'(o_efuse_crc_err), 32'(ec));
        chk({nm, "_nwrites"}, 32'(wq.size()), 32'(N));
        for (int i = 0; i < N; i++) begin
            if (i < wq.size()) chk({nm, "_write"}, 32'(wq[i]), 32'({5'd0, 3'(i), mem[i]}));
        end
        @(negedge clk);
        chk({nm, "_done_width"}, 32'(o_efuse_load_done), 32'(0));
        if (hold_cycles > 0) begin
            act = 0;
            repeat (hold_cycles) begin
                @(negedge clk);
                if (o_efuse_strobe || o_efuse_load_done || o_reg_efuse_wr_en || !o_efuse_busy || !o_efuse_csb) act++;
            end
            chk({nm, "_hold_quiet"}, 32'(act), 32'(0));
        end
        req = 1'b0;
        repeat (3) @(negedge clk);
        chk({nm, "_end"}, 32'({o_efuse_busy, o_efuse_csb, o_efuse_vld, o_efuse_crc_err}),
            32'({1'b0, 1'b1, ev, ec}));
    endtask

    localparam logic [20:0] RST_OUTS = {6'b000010, 3'd0, 1'b0, 3'd0, 8'h00};

    function automatic logic [20:0] outs();
        return {o_efuse_load_done, o_efuse_vld, o_efuse_crc_err, o_efuse_busy, o_efuse_csb,
                o_efuse_strobe, o_efuse_addr, o_reg_efuse_wr_en, o_reg_efuse_wr_addr, o_reg_efuse_wr_data};
    endfunction

    initial begin
        int         n;
        int         dn;
        logic [7:0] t1 [N];
        t1 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h7F};
        rst  = 1'b1;
        req  = 1'b0;
        junk = 8'h00;
        for (int i = 0; i < N; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outs", 32'(outs()), 32'(RST_OUTS));
        rst = 1'b0;
        @(negedge clk);

        // T1 good load
        for (int i = 0; i < N; i++) mem[i] = t1[i];
        run_load("t1", 0, 0);
        // T2 bad checksum
        mem[N-1] = 8'h7E;
        run_load("t2", 0, 0);
        // T3 blank
        fill_mem(2);
        run_load("t3", 0, 0);

        // T5 reset during word 3 strobe
        for (int i = 0; i < N; i++) mem[i] = t1[i];
        run_load("t5_pre", 0, 0);
        req = 1'b1;
        n   = 0;
        while (!(o_efuse_strobe && o_efuse_addr == 3'd3) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach_word3", 32'(o_efuse_strobe && o_efuse_addr == 3'd3), 32'(1));
        rst = 1'b1;
        req = 1'b0;
        @(negedge clk);
        chk("t5_reset_outs", 32'(outs()), 32'(RST_OUTS));
        @(negedge clk);
        rst = 1'b0;
        dn  = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_efuse_load_done || o_efuse_busy) dn++;
        end
        chk("t5_no_done", 32'(dn), 32'(0));
        run_load("t5_post", 0, 0);

        // T6 early req drop, then req held high after done, then re-request
        run_load("t6_drop", 10, 0);
        mem[N-1] = 8'h00;
        run_load("t6_hold", 0, 20);
        mem[N-1] = 8'h7F;
        run_load("t6_again", 0, 0);

        // Randomized loads
        for (int k = 0; k < 8; k++) begin
            fill_mem(int'($urandom_range(0, 2)));
            run_load("rand", (k == 3) ? int'($urandom_range(1, 50)) : 0, (k == 5) ? 7 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
